// File: rtl/serial_sub32_pkg.sv
// Shared definitions for the serial arithmetic blocks: state encoding,
// default geometry and counter sizing.
package serial_sub32_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must be at least one bit wide even for a single-digit operation.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_sub32_sub_digit.sv
// One DIGIT_W-bit slice of the subtractor: {bout, d} = a - b - bin.
module sub_digit #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               bin_i,
    output logic [DIGIT_W-1:0] d_o,
    output logic               bout_o
);

    logic [DIGIT_W:0] full;

    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT_W{1'b0}}, bin_i};
    assign d_o    = full[DIGIT_W-1:0];
    assign bout_o = full[DIGIT_W];

endmodule

// File: rtl/serial_sub32.sv
// Multi-cycle subtractor: a - b - bin computed DIGIT_W bits per clock with
// the borrow carried between cycles in a register; valid/ready on both sides.
module serial_sub32
    import serial_sub32_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int unsigned N     = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W = cnt_width(N);

    if (WIDTH % DIGIT_W != 0) begin : g_width_check
        $error("serial_sub32: WIDTH must be a multiple of DIGIT_W");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT_W-1:0] dig_d;
    logic               dig_bout;
    logic [WIDTH-1:0]   res_shift;

    sub_digit #(.DIGIT_W(DIGIT_W)) u_sub_digit (
        .a_i    (a_sh_q[DIGIT_W-1:0]),
        .b_i    (b_sh_q[DIGIT_W-1:0]),
        .bin_i  (borrow_q),
        .d_o    (dig_d),
        .bout_o (dig_bout)
    );

    // New digit enters at the MSB end so the result is aligned after N shifts.
    assign res_shift = (res_q >> DIGIT_W) | (WIDTH'(dig_d) << (WIDTH - DIGIT_W));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    borrow_d = bin_i;
                    a_msb_d  = a_i[WIDTH-1];
                    b_msb_d  = b_i[WIDTH-1];
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_sh_d   = a_sh_q >> DIGIT_W;
                b_sh_d   = b_sh_q >> DIGIT_W;
                res_d    = res_shift;
                borrow_d = dig_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = dig_bout;
                    zero_d  = (res_shift == '0);
                    ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign diff_o      = diff_q;
    assign bout_o      = bout_q;
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;

endmodule
